aes_job_ctrl: RTL and testbench
===============================

AES_JOB_CTRL -- requirements
Module: aes_job_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 2: cycles the AES core is held in reset before each job (range 1..15).
REQ-002 Parameter TIMEOUT, default 64: maximum RUN cycles waiting for core_done (range 2..255).
REQ-003 clk  in  1  single system clock; all state changes on posedge clk.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 key_valid  in  1  key generator output key is stable and usable.
REQ-006 pt_valid / pt_ready  in / out  1 / 1  plaintext handshake; transfer when both high on posedge clk.
REQ-007 pt_data  in  128  plaintext block.
REQ-008 core_rst  out  1  active-high reset to the AES core.
REQ-009 core_data  out  128  plaintext presented to the AES core.
REQ-010 core_done  in  1  AES core result-valid flag.
REQ-011 core_result  in  128  AES core ciphertext.
REQ-012 ct_valid / ct_ready  out / in  1 / 1  ciphertext handshake; transfer when both high.
REQ-013 ct_data  out  128  ciphertext block.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 err  out  2  sticky error: bit0 = timeout, bit1 = key lost mid-job.
REQ-016 job_cnt  out  8  count of completed ciphertext transfers.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, RUN, HOLD.
REQ-018 IDLE: pt_ready = key_valid; core_rst = 1; core_data = 0. On a pt transfer: latch pt_data, clear reset counter, go to LOAD.
REQ-019 LOAD: core_rst = 1 and core_data = latched plaintext for exactly RST_CYCLES cycles, then go to RUN.
REQ-020 RUN: core_rst = 0, core_data held, timeout counter increments each cycle from 0.
REQ-021 RUN: core_done = 1 SHALL latch core_result into ct_data and go to HOLD the next cycle; core_done is ignored in every other state.
REQ-022 RUN: timeout counter reaching TIMEOUT without core_done SHALL set err[0] and return to IDLE; no ct_valid is issued.
REQ-023 HOLD: ct_valid = 1, ct_data stable, core_rst = 1. On ct_ready = 1: job_cnt increments, go to IDLE.
REQ-024 ct_valid SHALL remain high with ct_data unchanged until accepted; ct_valid never deasserts without a transfer except on reset.
REQ-025 key_valid falling in LOAD or RUN SHALL abort to IDLE, set err[1], and assert core_rst the same cycle as the state change. In HOLD it does not abort (result already captured).
REQ-026 If core_done and the timeout limit occur in the same RUN cycle, core_done wins: no err[0], go to HOLD.
REQ-027 If key_valid falls and core_done occurs in the same RUN cycle, abort wins: err[1] set, result discarded.
REQ-028 pt_ready SHALL be 0 in LOAD, RUN and HOLD; no back-to-back acceptance in the HOLD->IDLE cycle (first new acceptance is 1 cycle after returning to IDLE).
REQ-029 job_cnt SHALL wrap 255 -> 0 with no flag.
REQ-030 err bits are sticky; cleared only by reset.
REQ-031 Minimum latency pt transfer -> ct_valid = RST_CYCLES + 2 + (cycles until core_done).

Reset
REQ-032 reset low SHALL immediately (asynchronously) force: state IDLE, pt_ready 0, core_rst 1, core_data 0, ct_valid 0, ct_data 0, busy 0, err 0, job_cnt 0, all internal counters 0.
REQ-033 Reset asserted mid-job SHALL discard the job; after release the block accepts a new plaintext once key_valid = 1.

Verification
REQ-034 Nominal: key_valid=1, pt_data=00112233445566778899aabbccddeeff, core model returns 69c4e0d86a7b0430d8cdb78070b4c55a after 11 cycles, ct_ready=1 -> ct_data equals that value, job_cnt=1, err=0.
REQ-035 Backpressure: ct_ready=0 for 20 cycles in HOLD -> ct_valid and ct_data stable throughout; pt_ready=0; transfer on first ct_ready=1.
REQ-036 Timeout: core_done never asserted, TIMEOUT=64 -> return to IDLE after 64 RUN cycles, err=2'b01, no ct_valid.
REQ-037 Key loss: drop key_valid 3 cycles into RUN -> IDLE next edge, err=2'b10, core_rst=1, pt_ready=0 until key_valid returns.
REQ-038 Simultaneous: core_done on cycle TIMEOUT -> HOLD, err=0; separate run with key_valid fall plus core_done same cycle -> IDLE, err=2'b10.
REQ-039 Reset mid-RUN and wrap: assert reset in RUN -> all outputs at reset values asynchronously; separately, 256 completed jobs -> job_cnt=0.

Source files
------------

// File: rtl/aes_job_ctrl_if.sv
// Plaintext-in / ciphertext-out streaming bundle for the AES job controller.
//   pt_valid/pt_ready/pt_data : plaintext block offered by the host
//   ct_valid/ct_ready/ct_data : ciphertext block returned to the host
// The controller connects through the slave modport; the host (or a bench)
// uses the master modport.
interface aes_job_ctrl_if;
  logic         pt_valid;
  logic         pt_ready;
  logic [127:0] pt_data;
  logic         ct_valid;
  logic         ct_ready;
  logic [127:0] ct_data;

  modport master (
    output pt_valid, pt_data, ct_ready,
    input  pt_ready, ct_valid, ct_data
  );

  modport slave (
    input  pt_valid, pt_data, ct_ready,
    output pt_ready, ct_valid, ct_data
  );
endinterface

// File: rtl/aes_job_ctrl.sv
// AES job controller: accepts one plaintext block at a time, holds the AES
// core in reset for RST_CYCLES cycles with the block presented, releases it
// and waits up to TIMEOUT cycles for core_done, then offers the captured
// ciphertext until the host takes it.
// Ports:
//   clk, reset     : system clock, asynchronous active-low reset
//   key_valid      : key generator output is usable; loss aborts a job
//   io (slave)     : plaintext / ciphertext valid-ready streams
//   core_rst       : active-high reset to the AES core
//   core_data      : plaintext presented to the AES core
//   core_done      : AES core result valid
//   core_result    : AES core ciphertext
//   busy           : controller is not idle
//   err            : sticky errors, bit0 timeout, bit1 key lost mid-job
//   job_cnt        : completed ciphertext transfers, wraps at 256
module aes_job_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          key_valid,
  aes_job_ctrl_if.slave io,
  output logic          core_rst,
  output logic [127:0]  core_data,
  input  logic          core_done,
  input  logic [127:0]  core_result,
  output logic          busy,
  output logic [1:0]    err,
  output logic [7:0]    job_cnt
);

  localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   rst_cnt_q, rst_cnt_d;
  logic [7:0]   to_cnt_q, to_cnt_d;
  logic [127:0] pt_q, pt_d;
  logic [127:0] ct_q, ct_d;
  logic [1:0]   err_q, err_d;
  logic [7:0]   job_cnt_q, job_cnt_d;
  logic         armed_q;
  logic         pt_ready_c;
  logic         ct_valid_c;

  // State and datapath registers. armed_q keeps pt_ready low while reset is
  // held and for the first edge after release, so no plaintext can slip in
  // while the block is still being reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rst_cnt_q <= '0;
      to_cnt_q  <= '0;
      pt_q      <= '0;
      ct_q      <= '0;
      err_q     <= '0;
      job_cnt_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      to_cnt_q  <= to_cnt_d;
      pt_q      <= pt_d;
      ct_q      <= ct_d;
      err_q     <= err_d;
      job_cnt_q <= job_cnt_d;
      armed_q   <= 1'b1;
    end
  end

  // Next-state and output decode. Key loss outranks core_done, and core_done
  // outranks the timeout, so a result arriving on the last allowed RUN cycle
  // is still delivered.
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    to_cnt_d   = to_cnt_q;
    pt_d       = pt_q;
    ct_d       = ct_q;
    err_d      = err_q;
    job_cnt_d  = job_cnt_q;
    pt_ready_c = 1'b0;
    ct_valid_c = 1'b0;
    core_rst   = 1'b1;
    core_data  = pt_q;

    unique case (state_q)
      IDLE: begin
        core_data  = '0;
        pt_ready_c = armed_q & key_valid;
        if (pt_ready_c && io.pt_valid) begin
          pt_d      = io.pt_data;
          rst_cnt_d = '0;
          state_d   = LOAD;
        end
      end

      LOAD: begin
        if (!key_valid) begin
          err_d[1] = 1'b1;
          state_d  = IDLE;
        end else if (rst_cnt_q == RST_LAST) begin
          to_cnt_d = '0;
          state_d  = RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 4'd1;
        end
      end

      RUN: begin
        core_rst = 1'b0;
        if (!key_valid) begin
          err_d[1] = 1'b1;
          state_d  = IDLE;
        end else if (core_done) begin
          ct_d    = core_result;
          state_d = HOLD;
        end else if (to_cnt_q == TO_LAST) begin
          err_d[0] = 1'b1;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end

      HOLD: begin
        ct_valid_c = 1'b1;
        if (io.ct_ready) begin
          job_cnt_d = job_cnt_q + 8'd1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign io.pt_ready = pt_ready_c;
  assign io.ct_valid = ct_valid_c;
  assign io.ct_data  = ct_q;
  assign busy        = (state_q != IDLE);
  assign err         = err_q;
  assign job_cnt     = job_cnt_q;

endmodule

// File: tb/tb_aes_job_ctrl.sv
// Directed bench for aes_job_ctrl with default parameters (RST_CYCLES=2,
// TIMEOUT=64). A small behavioural AES core raises core_done a set number of
// cycles after core_rst drops, or can be driven by hand.
module tb_aes_job_ctrl;

  localparam logic [127:0] PT_NOM = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_NOM = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_BP  = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] CT_BP  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic         clk;
  logic         reset;
  logic         key_valid;
  logic         core_rst;
  logic [127:0] core_data;
  logic         core_done;
  logic [127:0] core_result;
  logic         busy;
  logic [1:0]   err;
  logic [7:0]   job_cnt;

  aes_job_ctrl_if io ();

  int  err_count;
  int  check_count;
  int  run_cycles;
  int  core_delay;
  bit  core_auto;
  bit  core_done_man;

  aes_job_ctrl #(.RST_CYCLES(2), .TIMEOUT(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .io          (io.slave),
    .core_rst    (core_rst),
    .core_data   (core_data),
    .core_done   (core_done),
    .core_result (core_result),
    .busy        (busy),
    .err         (err),
    .job_cnt     (job_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: counts cycles spent out of reset; in auto mode core_done is
  // high in the core_delay-th cycle after core_rst drops.
  always @(posedge clk) begin
    if (core_rst) run_cycles <= 0;
    else          run_cycles <= run_cycles + 1;
  end

  assign core_done = core_auto ? (!core_rst && (run_cycles == core_delay - 1))
                               : core_done_man;

  task automatic checkOutput(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
    check_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Offer one plaintext block; returns one step after the transfer edge.
  task automatic applyStimulus(input logic [127:0] data);
    int n;
    n = 0;
    while (!io.pt_ready && n < 20) begin
      tick();
      n++;
    end
    checkOutput("pt_ready_wait", 128'(io.pt_ready), 128'd1);
    io.pt_valid = 1'b1;
    io.pt_data  = data;
    tick();
    io.pt_valid = 1'b0;
  endtask

  task automatic waitCtValid(input int limit, output int n);
    n = 0;
    while (!io.ct_valid && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic waitRun(output int n);
    n = 0;
    while (core_rst && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int  n;
    bit  saw_ct;
    bit  wrap_to;

    err_count     = 0;
    check_count   = 0;
    run_cycles    = 0;
    core_delay    = 11;
    core_auto     = 1'b1;
    core_done_man = 1'b0;
    core_result   = CT_NOM;
    key_valid     = 1'b1;
    io.pt_valid   = 1'b0;
    io.pt_data    = '0;
    io.ct_ready   = 1'b0;
    reset         = 1'b0;

    // Reset state with key_valid already high.
    #3;
    checkOutput("rst_pt_ready", 128'(io.pt_ready), 128'd0);
    checkOutput("rst_core_rst", 128'(core_rst),    128'd1);
    checkOutput("rst_core_data", core_data,        128'd0);
    checkOutput("rst_ct_valid", 128'(io.ct_valid), 128'd0);
    checkOutput("rst_ct_data",  io.ct_data,        128'd0);
    checkOutput("rst_busy",     128'(busy),        128'd0);
    checkOutput("rst_err",      128'(err),         128'd0);
    checkOutput("rst_job_cnt",  128'(job_cnt),     128'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Nominal job: 2 LOAD cycles + 11 RUN cycles before HOLD.
    checkOutput("nom_pt_ready_idle", 128'(io.pt_ready), 128'd1);
    io.ct_ready = 1'b1;
    applyStimulus(PT_NOM);
    checkOutput("nom_load_pt_ready", 128'(io.pt_ready), 128'd0);
    checkOutput("nom_load_core_rst", 128'(core_rst),    128'd1);
    checkOutput("nom_load_core_data", core_data,        PT_NOM);
    checkOutput("nom_load_busy",     128'(busy),        128'd1);
    waitCtValid(100, n);
    checkOutput("nom_latency",   128'(n),           128'd13);
    checkOutput("nom_ct_valid",  128'(io.ct_valid), 128'd1);
    checkOutput("nom_ct_data",   io.ct_data,        CT_NOM);
    checkOutput("nom_hold_rst",  128'(core_rst),    128'd1);
    checkOutput("nom_hold_ptr",  128'(io.pt_ready), 128'd0);
    tick();
    checkOutput("nom_job_cnt",   128'(job_cnt),     128'd1);
    checkOutput("nom_err",       128'(err),         128'd0);
    checkOutput("nom_ct_valid_off", 128'(io.ct_valid), 128'd0);
    checkOutput("nom_busy_off",  128'(busy),        128'd0);
    checkOutput("nom_ptr_again", 128'(io.pt_ready), 128'd1);

    // Backpressure: 20 cycles of ct_ready low, core result changes meanwhile.
    io.ct_ready = 1'b0;
    core_result = CT_BP;
    applyStimulus(PT_BP);
    waitCtValid(100, n);
    checkOutput("bp_reach_hold", 128'(io.ct_valid), 128'd1);
    core_result = '1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("bp_ct_valid", 128'(io.ct_valid), 128'd1);
      checkOutput("bp_ct_data",  io.ct_data,        CT_BP);
      checkOutput("bp_pt_ready", 128'(io.pt_ready), 128'd0);
    end
    io.ct_ready = 1'b1;
    tick();
    checkOutput("bp_job_cnt",  128'(job_cnt),     128'd2);
    checkOutput("bp_ct_off",   128'(io.ct_valid), 128'd0);
    io.ct_ready = 1'b0;
    core_result = CT_NOM;

    // Timeout: no core_done, 2 LOAD + 64 RUN cycles then IDLE.
    core_auto     = 1'b0;
    core_done_man = 1'b0;
    applyStimulus(PT_NOM);
    n = 0;
    saw_ct = 1'b0;
    while (busy && n < 200) begin
      tick();
      n++;
      if (io.ct_valid) saw_ct = 1'b1;
    end
    checkOutput("to_cycles",   128'(n),       128'd66);
    checkOutput("to_err",      128'(err),     128'd1);
    checkOutput("to_no_ct",    128'(saw_ct),  128'd0);
    checkOutput("to_job_cnt",  128'(job_cnt), 128'd2);
    core_auto = 1'b1;

    // Key loss three cycles into RUN.
    applyReset();
    applyStimulus(PT_NOM);
    waitRun(n);
    checkOutput("kl_in_run", 128'(core_rst), 128'd0);
    tick();
    tick();
    key_valid = 1'b0;
    tick();
    checkOutput("kl_busy",     128'(busy),        128'd0);
    checkOutput("kl_err",      128'(err),         128'd2);
    checkOutput("kl_core_rst", 128'(core_rst),    128'd1);
    checkOutput("kl_pt_ready", 128'(io.pt_ready), 128'd0);
    tick();
    tick();
    tick();
    checkOutput("kl_pt_ready_later", 128'(io.pt_ready), 128'd0);
    key_valid = 1'b1;
    #1;
    checkOutput("kl_pt_ready_back", 128'(io.pt_ready), 128'd1);
    tick();

    // core_done on the 64th RUN cycle beats the timeout.
    applyReset();
    core_delay = 64;
    applyStimulus(PT_NOM);
    waitCtValid(200, n);
    checkOutput("sim_to_cycles",  128'(n),           128'd66);
    checkOutput("sim_to_ctvalid", 128'(io.ct_valid), 128'd1);
    checkOutput("sim_to_err",     128'(err),         128'd0);
    checkOutput("sim_to_ct_data", io.ct_data,        CT_NOM);
    io.ct_ready = 1'b1;
    tick();
    checkOutput("sim_to_job_cnt", 128'(job_cnt), 128'd1);
    io.ct_ready = 1'b0;
    core_delay  = 11;

    // Key loss and core_done in the same RUN cycle: abort wins.
    applyReset();
    core_auto = 1'b0;
    applyStimulus(PT_NOM);
    waitRun(n);
    tick();
    tick();
    key_valid     = 1'b0;
    core_done_man = 1'b1;
    tick();
    checkOutput("sim_kl_busy",    128'(busy),        128'd0);
    checkOutput("sim_kl_err",     128'(err),         128'd2);
    checkOutput("sim_kl_ctvalid", 128'(io.ct_valid), 128'd0);
    checkOutput("sim_kl_ct_data", io.ct_data,        128'd0);
    core_done_man = 1'b0;
    key_valid     = 1'b1;
    core_auto     = 1'b1;
    tick();

    // Asynchronous reset in RUN, then a fresh job afterwards.
    applyStimulus(PT_BP);
    waitRun(n);
    tick();
    checkOutput("mr_busy_before", 128'(busy), 128'd1);
    reset = 1'b0;
    #1;
    checkOutput("mr_pt_ready",  128'(io.pt_ready), 128'd0);
    checkOutput("mr_core_rst",  128'(core_rst),    128'd1);
    checkOutput("mr_core_data", core_data,         128'd0);
    checkOutput("mr_ct_valid",  128'(io.ct_valid), 128'd0);
    checkOutput("mr_busy",      128'(busy),        128'd0);
    checkOutput("mr_err",       128'(err),         128'd0);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("mr_pt_ready_after", 128'(io.pt_ready), 128'd1);
    io.ct_ready = 1'b1;
    applyStimulus(PT_NOM);
    waitCtValid(100, n);
    checkOutput("mr_ct_data", io.ct_data, CT_NOM);
    tick();
    checkOutput("mr_job_cnt", 128'(job_cnt), 128'd1);

    // job_cnt wraps after 256 completed jobs.
    applyReset();
    core_delay = 1;
    wrap_to    = 1'b0;
    for (int j = 0; j < 256; j++) begin
      applyStimulus(128'(j));
      waitCtValid(50, n);
      if (!io.ct_valid) wrap_to = 1'b1;
      tick();
      if (j == 254) checkOutput("wrap_255", 128'(job_cnt), 128'd255);
    end
    checkOutput("wrap_timeouts", 128'(wrap_to), 128'd0);
    checkOutput("wrap_zero",     128'(job_cnt), 128'd0);
    checkOutput("wrap_err",      128'(err),     128'd0);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
